// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage ALU with an attached iterative multiply/divide unit.
//
// The ALU path (A, B, fun -> Y, C, V) is purely combinational and never looks at
// the mul/div state. The mul/div unit takes WIDTH shift-add or restoring-subtract
// steps on operand magnitudes, then applies sign correction while writing HI/LO.
//
// Parameters:
//   WIDTH        datapath width (even, >= 4)
// Ports:
//   clk, rst_n   clock (rising edge), synchronous active-low reset
//   A, B         operands (rs, rt)
//   fun          ALU function: fun[2] inverts B and adds carry-in,
//                fun[1:0] = 00 AND, 01 OR, 10 ADD, 11 SLT
//   Y, C, V      ALU result, adder carry out, adder signed overflow
//   start        mul/div request; accepted only when busy=0
//   md_op        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   busy         mul/div in progress (accept edge through the HI/LO write edge)
//   done         one-cycle pulse after HI/LO were written
//   hi, lo       HI/LO registers
// Optional feature (macro ALU_HILO_WRITE_EN):
//   hilo_wdata, hi_we, lo_we  MTHI/MTLO write port, honoured only while busy=0.
//
// Handshake: a request is taken on a rising edge where start=1 and busy=0; start
// is ignored while busy=1 and is never queued. The result is visible on hi/lo in
// the same cycle that done is high.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       fun,
    output logic [WIDTH-1:0] Y,
    output logic             C,
    output logic             V,
    input  logic             start,
    input  logic [1:0]       md_op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef ALU_HILO_WRITE_EN
    ,
    input  logic [WIDTH-1:0] hilo_wdata,
    input  logic             hi_we,
    input  logic             lo_we
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // ---------------- combinational ALU ----------------
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum_ext;
    logic             add_v;

    assign bx      = fun[2] ? ~B : B;
    assign sum_ext = {1'b0, A} + {1'b0, bx} + {{WIDTH{1'b0}}, fun[2]};
    // Overflow: operands agree in sign but the sum does not.
    assign add_v   = (A[WIDTH-1] == bx[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);

    always_comb begin
        Y = '0;
        C = 1'b0;
        V = 1'b0;
        case (fun[1:0])
            2'b00: Y = A & bx;
            2'b01: Y = A | bx;
            2'b10: begin
                Y = sum_ext[WIDTH-1:0];
                C = sum_ext[WIDTH];
                V = add_v;
            end
            default: begin
                // True sign of the (possibly overflowed) difference.
                Y = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH-1] ^ add_v};
                C = sum_ext[WIDTH];
                V = add_v;
            end
        endcase
    end

    // ---------------- mul/div FSM ----------------
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [1:0]       op_q;      // op_q[1]: divide, op_q[0]: unsigned
    logic [WIDTH-1:0] a_q;       // raw dividend, needed for divide-by-zero HI
    logic [WIDTH-1:0] opnd_q;    // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0] r_hi;      // partial product high / partial remainder
    logic [WIDTH-1:0] r_lo;      // multiplier shifting out / quotient shifting in
    logic             neg_res;   // negate product or quotient in FIX
    logic             neg_rem;   // negate remainder in FIX
    logic             div0_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (cnt == LAST) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    // Operand magnitudes at accept time.
    logic             sgn, a_neg, b_neg;
    logic [WIDTH-1:0] ma, mb;
    assign sgn   = ~md_op[0];
    assign a_neg = sgn & A[WIDTH-1];
    assign b_neg = sgn & B[WIDTH-1];
    assign ma    = a_neg ? -A : A;
    assign mb    = b_neg ? -B : B;

    // One iteration of each algorithm.
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     shifted;
    logic               ge;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign msum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, opnd_q} : '0);
    assign shifted  = {r_hi, r_lo[WIDTH-1]};
    assign ge       = shifted >= {1'b0, opnd_q};
    // Only used when ge, where the true difference is below opnd_q and fits.
    assign diff     = shifted[WIDTH-1:0] - opnd_q;
    assign prod     = {r_hi, r_lo};
    assign prod_fix = neg_res ? -prod : prod;
    assign quo_fix  = neg_res ? -r_lo : r_lo;
    assign rem_fix  = neg_rem ? -r_hi : r_hi;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            op_q    <= '0;
            a_q     <= '0;
            opnd_q  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0_q  <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
`ifdef ALU_HILO_WRITE_EN
            if (!busy) begin
                if (hi_we) hi <= hilo_wdata;
                if (lo_we) lo <= hilo_wdata;
            end
`endif
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        op_q    <= md_op;
                        a_q     <= A;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        div0_q  <= (B == '0);
                        r_hi    <= '0;
                        // Multiply shifts the multiplier out of r_lo; divide shifts
                        // the dividend out of r_lo while the quotient shifts in.
                        r_lo    <= md_op[1] ? ma : mb;
                        opnd_q  <= md_op[1] ? mb : ma;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CW'(1);
                    if (op_q[1]) begin
                        r_hi <= ge ? diff : shifted[WIDTH-1:0];
                        r_lo <= {r_lo[WIDTH-2:0], ge};
                    end else begin
                        {r_hi, r_lo} <= {msum, r_lo[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    done <= 1'b1;
                    if (op_q[1]) begin
                        if (div0_q) begin
                            hi <= a_q;
                            lo <= '1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;
  localparam int W = 32;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] A, B, Y, hi, lo;
  logic [2:0]   fun;
  logic         C, V, start, busy, done;
  logic [1:0]   md_op;
`ifdef ALU_HILO_WRITE_EN
  logic [W-1:0] hilo_wdata;
  logic         hi_we, lo_we;
`endif

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .fun(fun), .Y(Y), .C(C), .V(V),
    .start(start), .md_op(md_op), .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef ALU_HILO_WRITE_EN
    , .hilo_wdata(hilo_wdata), .hi_we(hi_we), .lo_we(lo_we)
`endif
  );

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic void md_model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [1:0] op,
                                   output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] p, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    h = '0;
    l = '0;
    case (op)
      2'b00: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
      2'b10: begin
        if (b == 0) begin h = a; l = '1; end
        else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
      end
      default: begin
        if (b == 0) begin h = a; l = '1; end
        else begin p = ua / ub; l = p[31:0]; p = ua % ub; h = p[31:0]; end
      end
    endcase
  endfunction

  bit          m_busy = 1'b0, m_done = 1'b0, pre_busy;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
    end else begin
      pre_busy = m_busy;
      m_done = 1'b0;
`ifdef ALU_HILO_WRITE_EN
      if (!pre_busy) begin
        if (hi_we) m_hi = hilo_wdata;
        if (lo_we) m_lo = hilo_wdata;
      end
`endif
      if (pre_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_hi = p_hi; m_lo = p_lo;
        end
      end else if (start) begin
        md_model(A, B, md_op, p_hi, p_lo);
        m_busy = 1'b1;
        m_left = W + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_busy", 64'(busy), 64'(m_busy));
      chk("cyc_done", 64'(done), 64'(m_done));
      chk("cyc_hi",   64'(hi),   64'(m_hi));
      chk("cyc_lo",   64'(lo),   64'(m_lo));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    logic [31:0] bx, ey;
    logic        ec, ev;
    longint      full;
    A = a; B = b; fun = f;
    #1;
    bx = f[2] ? ~b : b;
    ec = 1'b0; ev = 1'b0; ey = '0;
    case (f[1:0])
      2'b00: ey = a & bx;
      2'b01: ey = a | bx;
      default: begin
        if (f[2]) begin
          full = longint'($signed(a)) - longint'($signed(b));
          ec   = (a >= b);
          ey   = a - b;
        end else begin
          full = longint'($signed(a)) + longint'($signed(b));
          ec   = (({32'h0, a} + {32'h0, b}) > 64'h0000_0000_FFFF_FFFF);
          ey   = a + b;
        end
        ev = (full > 64'sd2147483647) || (full < -64'sd2147483648);
        if (f[1:0] == 2'b11) ey = (full < 0) ? 32'd1 : 32'd0;
      end
    endcase
    chk("alu_y", 64'(Y), 64'(ey));
    chk("alu_c", 64'(C), 64'(ec));
    chk("alu_v", 64'(V), 64'(ev));
  endtask

  // Called at a negedge; start is raised now, so in the done cycle of a
  // previous op this gives a back-to-back request.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [31:0] eh, input logic [31:0] el, input int poke_at);
    int n = 0;
    bit seen = 1'b0;
    A = a; B = b; md_op = op; start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 1'b0; A = $urandom; B = $urandom; md_op = 2'($urandom_range(0, 3));
      end
      if (i == poke_at) start = 1'b1;
      if (i == poke_at + 1) start = 1'b0;
      if (done) begin seen = 1'b1; break; end
      if (busy) n++;
    end
    chk("md_done_seen", 64'(seen), 64'd1);
    chk("md_busy_cycles", 64'(n), 64'd33);
    chk("md_hi_lit", 64'(hi), 64'(eh));
    chk("md_lo_lit", 64'(lo), 64'(el));
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    chk("wait_done", 64'(seen), 64'd1);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] a, b;
    logic [2:0]  f;
    logic [31:0] y;
    logic        c, v;
  } alu_vec_t;

  alu_vec_t alu_tab[12] = '{
    '{32'h00000005, 32'h00000007, 3'b110, 32'hFFFFFFFE, 1'b0, 1'b0},
    '{32'hFFFFFFFF, 32'h00000001, 3'b111, 32'h00000001, 1'b1, 1'b0},
    '{32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b0, 1'b1},
    '{32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 1'b1, 1'b0},
    '{32'h80000000, 32'h00000001, 3'b110, 32'h7FFFFFFF, 1'b1, 1'b1},
    '{32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 32'h00F000F0, 1'b0, 1'b0},
    '{32'h00000000, 32'hFFFF0000, 3'b101, 32'h0000FFFF, 1'b0, 1'b0},
    '{32'h00000005, 32'hFFFFFFFD, 3'b111, 32'h00000000, 1'b0, 1'b0},
    '{32'hFFFFFFFD, 32'h00000005, 3'b111, 32'h00000001, 1'b1, 1'b0},
    '{32'h80000000, 32'h00000001, 3'b111, 32'h00000001, 1'b1, 1'b1},
    '{32'h12345678, 32'h11111111, 3'b001, 32'h13355779, 1'b0, 1'b0},
    '{32'h00000003, 32'h00000004, 3'b011, 32'h00000000, 1'b0, 1'b0}
  };

  typedef struct {
    logic [31:0] a, b;
    logic [1:0]  op;
    logic [31:0] eh, el;
  } md_vec_t;

  md_vec_t md_tab[12] = '{
    '{32'hFFFFFFFD, 32'h00000007, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFEB},
    '{32'hFFFFFFFF, 32'h00000002, 2'b01, 32'h00000001, 32'hFFFFFFFE},
    '{32'h00000064, 32'h00000007, 2'b11, 32'h00000002, 32'h0000000E},
    '{32'hFFFFFFF9, 32'h00000002, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFD},
    '{32'h00000005, 32'h00000000, 2'b11, 32'h00000005, 32'hFFFFFFFF},
    '{32'hFFFFFFFB, 32'h00000000, 2'b10, 32'hFFFFFFFB, 32'hFFFFFFFF},
    '{32'h80000000, 32'hFFFFFFFF, 2'b10, 32'h00000000, 32'h80000000},
    '{32'h80000000, 32'h80000000, 2'b00, 32'h40000000, 32'h00000000},
    '{32'h00000007, 32'hFFFFFFFE, 2'b10, 32'h00000001, 32'hFFFFFFFD},
    '{32'h7FFFFFFF, 32'hFFFFFFFF, 2'b00, 32'hFFFFFFFF, 32'h80000001},
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'hFFFFFFFE, 32'h00000001},
    '{32'hFFFFFFFF, 32'h00000010, 2'b11, 32'h0000000F, 32'h0FFFFFFF}
  };

  initial begin
    bit done_seen;
    logic [31:0] mh, ml;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; fun = '0; md_op = '0;
`ifdef ALU_HILO_WRITE_EN
    hilo_wdata = '0; hi_we = 1'b0; lo_we = 1'b0;
`endif
    @(negedge clk);
    check_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi",   64'(hi),   64'd0);
    chk("rst_lo",   64'(lo),   64'd0);

    // Model pinned by hand-computed results.
    md_model(32'hFFFFFFFD, 32'h7, 2'b00, mh, ml);
    chk("model_mult", {32'(mh), 32'(ml)}, 64'hFFFFFFFF_FFFFFFEB);
    md_model(32'hFFFFFFF9, 32'h2, 2'b10, mh, ml);
    chk("model_div", {32'(mh), 32'(ml)}, 64'hFFFFFFFF_FFFFFFFD);

    // ALU path: literal expectations plus model.
    foreach (alu_tab[i]) begin
      @(negedge clk);
      check_alu(alu_tab[i].a, alu_tab[i].b, alu_tab[i].f);
      chk("alu_lit_y", 64'(Y), 64'(alu_tab[i].y));
      chk("alu_lit_c", 64'(C), 64'(alu_tab[i].c));
      chk("alu_lit_v", 64'(V), 64'(alu_tab[i].v));
    end

    // Mul/div chain, each request issued in the done cycle of the previous one.
    @(negedge clk);
    foreach (md_tab[i])
      run_op(md_tab[i].a, md_tab[i].b, md_tab[i].op, md_tab[i].eh, md_tab[i].el, -1);

    // start mid-operation is ignored.
    repeat (2) @(negedge clk);
    run_op(32'h00000006, 32'h00000007, 2'b01, 32'h00000000, 32'h0000002A, 5);

    // Reset ten cycles after accept abandons the op.
    @(negedge clk);
    A = 32'h00000009; B = 32'h00000009; md_op = 2'b01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hi",   64'(hi),   64'd0);
    chk("midrst_lo",   64'(lo),   64'd0);
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    chk("midrst_no_done", 64'(done_seen), 64'd0);

    // Random ALU vectors against the model.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_alu($urandom, $urandom, 3'($urandom_range(0, 7)));
    end

`ifdef ALU_HILO_WRITE_EN
    @(negedge clk);
    hilo_wdata = 32'h12345678; hi_we = 1'b1;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_idle", 64'(hi), 64'h12345678);
    hilo_wdata = 32'h9ABCDEF0; lo_we = 1'b1;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_idle", 64'(lo), 64'h9ABCDEF0);
    A = 32'd3; B = 32'd5; md_op = 2'b01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    hilo_wdata = 32'hDEADBEEF; hi_we = 1'b1; lo_we = 1'b1;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi_busy", 64'(hi), 64'h12345678);
    chk("mtlo_busy", 64'(lo), 64'h9ABCDEF0);
    wait_done();
    chk("mt_op_hi", 64'(hi), 64'h0);
    chk("mt_op_lo", 64'(lo), 64'hF);
    hilo_wdata = 32'hAAAA5555; hi_we = 1'b1;
    A = 32'd2; B = 32'd3; md_op = 2'b01; start = 1'b1;
    @(negedge clk);
    hi_we = 1'b0; start = 1'b0;
    chk("mthi_accept", 64'(hi), 64'hAAAA5555);
    chk("mthi_accept_busy", 64'(busy), 64'd1);
    wait_done();
    chk("mt_op2_hi", 64'(hi), 64'h0);
    chk("mt_op2_lo", 64'(lo), 64'h6);
`endif

    repeat (3) @(negedge clk);
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
